// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit accumulator CPU.
// Holds the fetch FSM state encoding, the opcode map and the bus widths.
package cpu_pkg;

  localparam int ADRS_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_OP   = 2'd0,
    S_ARG  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } fetch_state_e;

  localparam logic [DATA_W-1:0] OP_LDI  = 8'h01;
  localparam logic [DATA_W-1:0] OP_LD   = 8'h02;
  localparam logic [DATA_W-1:0] OP_ADDI = 8'h03;
  localparam logic [DATA_W-1:0] OP_ADD  = 8'h04;
  localparam logic [DATA_W-1:0] OP_ST   = 8'h05;
  localparam logic [DATA_W-1:0] OP_JMP  = 8'h06;

endpackage

// File: rtl/fetch_pc.sv
// Program counter for the fetch unit.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   inc_i               advance pc by one (modulo 256)
//   load_i, load_adrs_i load pc from a jump target
//   redirect_i,
//   redirect_adrs_i     load pc from execute; wins over load and increment
//   pc_o                current pc
//   out_of_range_o      pc points at or beyond the populated ROM
module fetch_pc
  import cpu_pkg::*;
#(
  parameter int                ROM_DEPTH = 32,
  parameter logic [ADRS_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADRS_W-1:0] load_adrs_i,
  input  logic              redirect_i,
  input  logic [ADRS_W-1:0] redirect_adrs_i,
  output logic [ADRS_W-1:0] pc_o,
  output logic              out_of_range_o
);

  // One extra bit so that ROM_DEPTH = 256 compares correctly (never faults).
  localparam logic [ADRS_W:0] DEPTH_L = (ADRS_W + 1)'(ROM_DEPTH);

  logic [ADRS_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_adrs_i;
    end else if (load_i) begin
      pc_d = load_adrs_i;
    end else if (inc_i) begin
      pc_d = pc_q + ADRS_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o           = pc_q;
  assign out_of_range_o = ({1'b0, pc_q} >= DEPTH_L);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch for the 8-bit accumulator CPU.
// Reads two-byte instructions (opcode, operand) from the program ROM,
// swallows unconditional jumps, and offers each remaining instruction to
// execute over a valid/ready handshake.
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   rom_adrs, rom_rd, rom_dout   ROM read port (data combinational)
//   instr_valid, instr_ready     handshake to execute
//   opcode, operand, instr_pc    the offered instruction
//   redirect, redirect_adrs      pc override from execute
//   fetch_err                    sticky out-of-range fetch fault
//
// state  | meaning
// S_OP   | reading opcode byte at pc
// S_ARG  | reading operand byte at pc
// S_HOLD | instruction offered to execute, waiting for ready
// S_ERR  | fetch fault, idle until redirect or reset
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ROM_DEPTH = 32,
  parameter logic [DATA_W-1:0] JMP_OP    = OP_JMP,
  parameter logic [ADRS_W-1:0] RESET_PC  = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADRS_W-1:0] rom_adrs,
  output logic              rom_rd,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] opcode,
  output logic [DATA_W-1:0] operand,
  output logic [ADRS_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADRS_W-1:0] redirect_adrs,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] opcode_q, opcode_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [ADRS_W-1:0] instr_pc_q, instr_pc_d;

  logic              pc_inc;
  logic              pc_load;
  logic [ADRS_W-1:0] pc;
  logic              pc_oor;

  fetch_pc #(
    .ROM_DEPTH (ROM_DEPTH),
    .RESET_PC  (RESET_PC)
  ) u_fetch_pc (
    .clk             (clk),
    .rst_n           (rst_n),
    .inc_i           (pc_inc),
    .load_i          (pc_load),
    .load_adrs_i     (rom_dout),
    .redirect_i      (redirect),
    .redirect_adrs_i (redirect_adrs),
    .pc_o            (pc),
    .out_of_range_o  (pc_oor)
  );

  // rom_dout is only looked at in S_OP/S_ARG with the range check passed,
  // so nothing from an unread or unpopulated ROM location is captured.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    opcode_d   = opcode_q;
    operand_d  = operand_q;
    instr_pc_d = instr_pc_q;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;

    if (redirect) begin
      state_d = S_OP;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_OP: begin
          if (pc_oor) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            opcode_d   = rom_dout;
            instr_pc_d = pc;
            pc_inc     = 1'b1;
            state_d    = S_ARG;
          end
        end
        S_ARG: begin
          if (pc_oor) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            operand_d = rom_dout;
            if (opcode_q == JMP_OP) begin
              pc_load = 1'b1;
              state_d = S_OP;
            end else begin
              pc_inc  = 1'b1;
              state_d = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            state_d = S_OP;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_OP;
        end
      endcase
    end

    valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_OP;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      opcode_q   <= opcode_d;
      operand_q  <= operand_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign rom_adrs    = pc;
  assign rom_rd      = (state_q == S_OP) || (state_q == S_ARG);
  assign instr_valid = valid_q;
  assign opcode      = opcode_q;
  assign operand     = operand_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural ROM, a reference walk of
// the program that fills a scoreboard, and directed cycle checks.
module tb_fetch_unit;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rom_adrs;
  logic       rom_rd;
  logic [7:0] rom_dout;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] opcode;
  logic [7:0] operand;
  logic [7:0] instr_pc;
  logic       redirect;
  logic [7:0] redirect_adrs;
  logic       fetch_err;

  logic [7:0]  mem [256];
  logic [23:0] sb_q [$];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  assign rom_dout = rom_rd ? mem[rom_adrs] : 8'hxx;

  fetch_unit #(
    .ROM_DEPTH (DEPTH),
    .JMP_OP    (8'h06),
    .RESET_PC  (8'h00)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rom_adrs      (rom_adrs),
    .rom_rd        (rom_rd),
    .rom_dout      (rom_dout),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .opcode        (opcode),
    .operand       (operand),
    .instr_pc      (instr_pc),
    .redirect      (redirect),
    .redirect_adrs (redirect_adrs),
    .fetch_err     (fetch_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference walk: the sequence of instructions execute should see when
  // fetching starts at 'start', with jumps consumed and fetch stopping at
  // the first out-of-range byte.
  function automatic void sb_push_walk(input logic [7:0] start, input int n);
    logic [7:0] p;
    logic [7:0] op;
    int         pushed;
    p      = start;
    pushed = 0;
    for (int guard = 0; guard < 64 && pushed < n; guard++) begin
      if (int'(p) >= DEPTH) break;
      op = mem[p];
      p  = p + 8'd1;
      if (int'(p) >= DEPTH) break;
      if (op == 8'h06) begin
        p = mem[p];
      end else begin
        sb_q.push_back({op, mem[p], p - 8'd1});
        p = p + 8'd1;
        pushed++;
      end
    end
  endfunction

  // Handshake monitor: valid && ready seen mid-cycle is consumed at the
  // next rising edge.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        check_eq("sb_instr", {8'h00, opcode, operand, instr_pc}, {8'h00, sb_q.pop_front()});
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h01; mem[8'h01] = 8'h00;
    mem[8'h02] = 8'h03; mem[8'h03] = 8'h05;
    mem[8'h04] = 8'h06; mem[8'h05] = 8'h14;
    mem[8'h08] = 8'h05; mem[8'h09] = 8'h1A;
    mem[8'h0A] = 8'h02; mem[8'h0B] = 8'h1A;
    mem[8'h0C] = 8'h06; mem[8'h0D] = 8'h00;
    mem[8'h10] = 8'h01; mem[8'h11] = 8'hAA;
    mem[8'h12] = 8'h03; mem[8'h13] = 8'hBB;
    mem[8'h14] = 8'h06; mem[8'h15] = 8'h08;
    mem[8'h1F] = 8'h02; mem[8'h20] = 8'h99;

    rst_n         = 1'b0;
    instr_ready   = 1'b0;
    redirect      = 1'b0;
    redirect_adrs = 8'h00;
    #1;
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_err", 32'(fetch_err), 32'd0);
    check_eq("rst_fields", {8'h00, opcode, operand, instr_pc}, 32'h0);
    check_eq("rst_rd", 32'(rom_rd), 32'd1);
    check_eq("rst_adrs", 32'(rom_adrs), 32'h00);

    // Reset release and first instruction
    @(negedge clk);
    rst_n = 1'b1;
    sb_push_walk(8'h00, 8);
    #1;
    check_eq("c0_adrs", 32'(rom_adrs), 32'h00);
    check_eq("c0_rd", 32'(rom_rd), 32'd1);
    tick();
    check_eq("c1_valid", 32'(instr_valid), 32'd0);
    tick();
    check_eq("c2_valid", 32'(instr_valid), 32'd1);
    check_eq("c2_fields", {8'h00, opcode, operand, instr_pc}, {8'h00, 24'h010000});

    // Backpressure
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", 32'(instr_valid), 32'd1);
      check_eq("bp_fields", {8'h00, opcode, operand, instr_pc}, {8'h00, 24'h010000});
      check_eq("bp_rd", 32'(rom_rd), 32'd0);
      check_eq("bp_adrs", 32'(rom_adrs), 32'h02);
      tick();
    end
    instr_ready = 1'b1;
    tick();
    check_eq("bp_next_adrs", 32'(rom_adrs), 32'h02);
    check_eq("bp_next_rd", 32'(rom_rd), 32'd1);
    check_eq("bp_next_valid", 32'(instr_valid), 32'd0);

    // Jumps 04->14 and 14->08, neither offered to execute
    for (int n = 0; n < 40 && !(rom_adrs == 8'h15 && rom_rd); n++) tick();
    check_eq("jmp_reach15", 32'(rom_adrs), 32'h15);
    tick();
    check_eq("jmp_adrs", 32'(rom_adrs), 32'h08);
    check_eq("jmp_rd", 32'(rom_rd), 32'd1);
    check_eq("jmp_no_valid", 32'(instr_valid), 32'd0);
    for (int n = 0; n < 20 && !instr_valid; n++) tick();
    check_eq("jmp_valid", 32'(instr_valid), 32'd1);
    check_eq("jmp_ipc", 32'(instr_pc), 32'h08);

    // Redirect while reading the operand at 0B
    for (int n = 0; n < 20 && rom_adrs != 8'h0B; n++) tick();
    check_eq("rd_in_arg", 32'(rom_adrs), 32'h0B);
    redirect      = 1'b1;
    redirect_adrs = 8'h10;
    tick();
    redirect = 1'b0;
    sb_q.delete();
    sb_push_walk(8'h10, 6);
    check_eq("redir_adrs", 32'(rom_adrs), 32'h10);
    check_eq("redir_rd", 32'(rom_rd), 32'd1);
    check_eq("redir_valid", 32'(instr_valid), 32'd0);
    for (int n = 0; n < 20 && !instr_valid; n++) tick();
    check_eq("redir_vld", 32'(instr_valid), 32'd1);
    check_eq("redir_fields", {8'h00, opcode, operand, instr_pc}, {8'h00, 24'h01AA10});

    // Redirect to 1F coincident with a handshake, then range fault at 20
    redirect      = 1'b1;
    redirect_adrs = 8'h1F;
    tick();
    redirect = 1'b0;
    check_eq("hs_redir_drained", 32'(sb_q.size()), 32'd5);
    sb_q.delete();
    check_eq("f_adrs0", 32'(rom_adrs), 32'h1F);
    check_eq("f_rd0", 32'(rom_rd), 32'd1);
    check_eq("f_valid0", 32'(instr_valid), 32'd0);
    tick();
    check_eq("f_adrs1", 32'(rom_adrs), 32'h20);
    check_eq("f_err1", 32'(fetch_err), 32'd0);
    tick();
    check_eq("f_err", 32'(fetch_err), 32'd1);
    check_eq("f_rd", 32'(rom_rd), 32'd0);
    check_eq("f_valid", 32'(instr_valid), 32'd0);
    repeat (3) tick();
    check_eq("f_err_sticky", 32'(fetch_err), 32'd1);
    check_eq("f_valid_sticky", 32'(instr_valid), 32'd0);
    redirect      = 1'b1;
    redirect_adrs = 8'h00;
    instr_ready   = 1'b0;
    tick();
    redirect = 1'b0;
    check_eq("f_clr_err", 32'(fetch_err), 32'd0);
    check_eq("f_clr_adrs", 32'(rom_adrs), 32'h00);
    check_eq("f_clr_rd", 32'(rom_rd), 32'd1);

    // Asynchronous reset while holding an instruction
    for (int n = 0; n < 20 && !instr_valid; n++) tick();
    check_eq("ar_valid", 32'(instr_valid), 32'd1);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("ar_valid0", 32'(instr_valid), 32'd0);
    check_eq("ar_adrs0", 32'(rom_adrs), 32'h00);
    check_eq("ar_fields0", {8'h00, opcode, operand, instr_pc}, 32'h0);
    check_eq("ar_rd", 32'(rom_rd), 32'd1);
    sb_q.delete();
    #1;
    rst_n       = 1'b1;
    instr_ready = 1'b1;
    sb_push_walk(8'h00, 3);
    for (int n = 0; n < 60 && sb_q.size() != 0; n++) tick();
    instr_ready = 1'b0;
    check_eq("ar_drained", 32'(sb_q.size()), 32'd0);
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch initiator for the 8-bit accumulator CPU; it is the master side of the program ROM read interface (address, read strobe, combinational data back).
- Every instruction is two bytes (opcode, operand). The block fetches both bytes, resolves unconditional jumps internally, and hands each complete instruction to the execute stage over a valid/ready handshake.
- It also accepts a PC redirect from execute and flags fetches beyond the populated ROM.

Parameters:
ROM_DEPTH, 32, number of populated ROM bytes; a fetch at address >= ROM_DEPTH is a fault (legal range 2..256).
JMP_OP, 8'h06, opcode consumed internally as an unconditional jump to the operand.
RESET_PC, 8'h00, PC value after reset.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
rom_adrs  out  8  ROM byte address (equals pc).
rom_rd  out  1  ROM read strobe; rom_dout is sampled only when high.
rom_dout  in  8  ROM data, combinational from rom_adrs in the same cycle.
instr_valid  out  1  opcode/operand/instr_pc hold a fetched instruction.
instr_ready  in  1  execute stage accepts the instruction.
opcode  out  8  fetched opcode byte.
operand  out  8  fetched operand byte.
instr_pc  out  8  address of the opcode byte.
redirect  in  1  load PC from redirect_adrs.
redirect_adrs  in  8  redirect target.
fetch_err  out  1  sticky fetch-range fault.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc = RESET_PC; state = S_OP.
  - instr_valid = 0, fetch_err = 0; opcode, operand and instr_pc = 0.
  - rom_rd is 1 combinationally (S_OP), rom_adrs = RESET_PC.
- Outputs by state:
  - rom_adrs = pc in all states.
  - rom_rd = 1 only in S_OP and S_ARG.
  - instr_valid = 1 only in S_HOLD, and it is registered.
- S_OP:
  - If pc >= ROM_DEPTH: go to S_ERR and set fetch_err.
  - Otherwise capture opcode <= rom_dout and instr_pc <= pc, set pc <= pc+1, go to S_ARG.
- S_ARG:
  - Apply the same range check.
  - Otherwise capture operand <= rom_dout and set pc <= pc+1.
  - If opcode == JMP_OP: set pc <= rom_dout and go to S_OP. The jump is never presented to execute.
  - Else go to S_HOLD.
- S_HOLD:
  - opcode, operand and instr_pc stay stable while instr_valid=1 && instr_ready=0.
  - A handshake (valid && ready at the clock edge) moves to S_OP.
- S_ERR:
  - rom_rd = 0 and fetch_err = 1; the block stays here until redirect or reset.
- Redirect:
  - redirect=1 has top priority in every state: pc <= redirect_adrs, state <= S_OP, fetch_err <= 0. Any partially fetched instruction is dropped.
  - In S_HOLD, a handshake in the same cycle still counts as consumed. Without a handshake, the held instruction is discarded.
  - instr_valid goes low the cycle after a redirect.
- Latency and throughput:
  - Opcode address to instr_valid is 2 cycles.
  - Best-case throughput is one instruction per 3 cycles. A taken JMP_OP costs 2 cycles with no issue.
- Arithmetic:
  - pc increments modulo 256. Wrap 8'hFF -> 8'h00 is reachable only when ROM_DEPTH=256.
  - The range check is unsigned.
- rom_dout is never sampled while rom_rd=0, so X from the ROM must not propagate.

Decomposition:
- Shared package cpu_pkg holds:
  - state typedef {S_OP, S_ARG, S_HOLD, S_ERR};
  - opcode constants OP_LDI=8'h01, OP_LD=8'h02, OP_ADDI=8'h03, OP_ADD=8'h04, OP_ST=8'h05, OP_JMP=8'h06;
  - ADRS_W=8 and DATA_W=8.
- One sub-module is natural: fetch_pc, the pc register with increment, load and redirect muxing plus the range comparator. The FSM and output registers stay in fetch_unit.

Test Plan:
- Reset release, ROM byte0=01, byte1=00 -> cycle 0 rom_adrs=00 rd=1; cycle 2 instr_valid=1, opcode=01, operand=00, instr_pc=00.
- Backpressure: hold instr_ready=0 for 5 cycles -> valid and fields stable; rd=0; rom_adrs=02; after ready=1 the next opcode fetch is at 02.
- Jump: ROM 0x14=06, 0x15=08 -> no valid for the jump; the fetch after 0x15 reads adrs 08; the next valid has instr_pc=08.
- Redirect in S_ARG to 8'h10 -> operand discarded; next cycle rom_adrs=10; the next valid has instr_pc=10.
- Range fault, ROM_DEPTH=32, redirect to 8'h1F -> opcode fetched at 1F, S_ARG at 20 sets fetch_err=1 and rd=0 with no valid; a later redirect to 00 clears fetch_err.
- rst_n asserted mid-S_HOLD -> instr_valid=0 and rom_adrs=00 immediately without waiting for clk; fetch restarts at 00.
